// File: rtl/mem_dump_tx_pkg.sv
// Shared constants and FSM encoding for the data-memory dump transmitter.
// ADDR_W/DATA_W match the processor's data memory.
package mem_dump_tx_pkg;

  localparam int DUMP_ADDR_W = 8;
  localparam int DUMP_DATA_W = 16;
  localparam logic [7:0] DUMP_HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_READ    = 3'd2,
    S_WAIT    = 3'd3,
    S_SEND_HI = 3'd4,
    S_SEND_LO = 3'd5,
    S_SUM     = 3'd6,
    S_DONE    = 3'd7
  } state_t;

endpackage

// File: rtl/mem_dump_tx.sv
// Reads a (possibly wrapping) range of data-memory words and streams them as
// header, hi/lo byte pairs and an XOR checksum over a valid/ready byte port.
module mem_dump_tx
  import mem_dump_tx_pkg::*;
#(
  parameter int         ADDR_W   = DUMP_ADDR_W,
  parameter int         DATA_W   = DUMP_DATA_W,
  parameter logic [7:0] HDR_BYTE = DUMP_HDR_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic [2:0]        dbg_state
);

  // Byte handshake: a byte moves when tx_valid && tx_ready at a rising edge;
  // while tx_valid is high and tx_ready low, tx_data is held unchanged.

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_q;
  logic [7:0]        lo_q;
  logic [7:0]        csum_q;
  logic [7:0]        tx_data_q;
  logic              last_word;

  assign last_word = (addr_q == last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    tx_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_HDR;
      end
      S_HDR: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        if (tx_ready) state_nxt = S_READ;
      end
      S_READ: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy      = 1'b1;
        state_nxt = S_SEND_HI;
      end
      S_SEND_HI: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        if (tx_ready) state_nxt = S_SEND_LO;
      end
      S_SEND_LO: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        if (tx_ready) state_nxt = last_word ? S_SUM : S_READ;
      end
      S_SUM: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        if (tx_ready) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // tx_data is loaded one state ahead so it is already stable when tx_valid rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      last_q    <= '0;
      lo_q      <= '0;
      csum_q    <= '0;
      tx_data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q    <= first_addr;
            last_q    <= last_addr;
            csum_q    <= '0;
            tx_data_q <= HDR_BYTE;
          end
        end
        S_WAIT: begin
          lo_q      <= mem_rdata[7:0];
          csum_q    <= csum_q ^ mem_rdata[15:8] ^ mem_rdata[7:0];
          tx_data_q <= mem_rdata[15:8];
        end
        S_SEND_HI: begin
          if (tx_ready) tx_data_q <= lo_q;
        end
        S_SEND_LO: begin
          if (tx_ready) begin
            if (last_word) tx_data_q <= csum_q;
            else           addr_q    <= addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign tx_data   = tx_data_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx: table of frames plus hand-written sequences
// for backpressure, start-while-busy and reset mid-frame.
module tb_mem_dump_tx;
  import mem_dump_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] first_addr = '0;
  logic [7:0] last_addr = '0;
  logic       busy, done, mem_rd_en, tx_valid;
  logic [7:0] mem_addr, tx_data;
  logic [15:0] mem_rdata;
  logic       tx_ready = 1'b1;
  logic [2:0] dbg_state;

  mem_dump_tx dut (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr),
    .last_addr(last_addr), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // data memory preloaded with mem[i] = i, synchronous read
  logic [15:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'(i);
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // monitors: sample away from the active edge
  logic [7:0] got_q[$];
  logic [7:0] addr_seen_q[$];
  int done_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (mem_rd_en) addr_seen_q.push_back(mem_addr);
      if (done) done_cnt++;
    end
  end

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] exp_addr_q[$];
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] first;
    logic [7:0] last;
    int         exp_len;
    logic [7:0] exp_csum;
    int         exp_cycles;
  } vec_t;

  // driver tasks
  int s_cyc;
  task automatic start_frame(input logic [7:0] f, input logic [7:0] l);
    got_q.delete();
    addr_seen_q.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    s_cyc      = cyc;
    @(posedge clk); #1;
    start      = 1'b0;
    first_addr = 8'($urandom_range(0, 255));
    last_addr  = 8'($urandom_range(0, 255));
    check("hdr_valid", {31'd0, tx_valid}, 32'd1);
    check("hdr_byte", {24'd0, tx_data}, 32'hA5);
  endtask

  task automatic finish_frame(input string name, input logic [7:0] f, input logic [7:0] l,
                              input int exp_len, input logic [7:0] exp_csum, input int exp_cycles);
    int n;
    logic [7:0] a;
    bit seen;
    n = int'(8'(l - f)) + 1;
    exp_q.delete();
    exp_addr_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = 0; k < n; k++) begin
      a = f + 8'(k);
      exp_addr_q.push_back(a);
      exp_q.push_back(mem[a][15:8]);
      exp_q.push_back(mem[a][7:0]);
    end
    exp_q.push_back(exp_csum);
    seen = 1'b0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({name, "_latency"}, cyc - s_cyc, exp_cycles);
    check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({name, "_len"}, got_q.size(), exp_len);
    check({name, "_len_model"}, exp_q.size(), exp_len);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    check({name, "_nreads"}, addr_seen_q.size(), exp_addr_q.size());
    for (int i = 0; i < exp_addr_q.size() && i < addr_seen_q.size(); i++)
      check($sformatf("%s_addr%0d", name, i), {24'd0, addr_seen_q[i]}, {24'd0, exp_addr_q[i]});
    repeat (2) @(negedge clk);
    check({name, "_done_low"}, {31'd0, done}, 32'd0);
    check({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    check({name, "_done_once"}, done_cnt, 1);
  endtask

  vec_t vecs[5];
  bit hit;
  int lo_seen;

  initial begin
    vecs[0] = '{8'd22,  8'd22,  4,   8'h16, 7};
    vecs[1] = '{8'd254, 8'd1,   10,  8'h00, 19};
    vecs[2] = '{8'd0,   8'd255, 514, 8'h00, 1027};
    vecs[3] = '{8'd7,   8'd10,  10,  8'h0C, 19};
    vecs[4] = '{8'd5,   8'd9,   12,  8'h05, 23};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    rst = 1'b0;

    // table-driven frames with tx_ready held high
    for (int v = 0; v < 5; v++) begin
      start_frame(vecs[v].first, vecs[v].last);
      finish_frame($sformatf("vec%0d", v), vecs[v].first, vecs[v].last,
                   vecs[v].exp_len, vecs[v].exp_csum, vecs[v].exp_cycles);
    end

    // backpressure: stall SEND_HI of word 3 for 5 cycles
    start_frame(8'd3, 8'd4);
    hit = 1'b0;
    for (int t = 0; t < 100 && !hit; t++) begin
      @(negedge clk);
      if (dbg_state == S_WAIT) hit = 1'b1;
    end
    check("bp_reach_wait", {31'd0, hit}, 32'd1);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, tx_valid}, 32'd1);
      check("bp_data", {24'd0, tx_data}, 32'h00);
      check("bp_no_read", {31'd0, mem_rd_en}, 32'd0);
      check("bp_state", {29'd0, dbg_state}, {29'd0, S_SEND_HI});
      @(posedge clk);
    end
    #1;
    tx_ready = 1'b1;
    finish_frame("bp", 8'd3, 8'd4, 6, 8'h07, 16);

    // start while busy is ignored
    start_frame(8'd10, 8'd12);
    repeat (4) @(posedge clk);
    #1;
    first_addr = 8'd100;
    last_addr  = 8'd101;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_frame("busy_start", 8'd10, 8'd12, 8, 8'h0D, 15);

    // reset during SEND_LO of the second word
    start_frame(8'd0, 8'd3);
    lo_seen = 0;
    for (int t = 0; t < 100 && lo_seen < 2; t++) begin
      @(negedge clk);
      if (dbg_state == S_SEND_LO) lo_seen++;
    end
    check("rst_mid_reach", lo_seen, 2);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_mid_no_done", done_cnt, 0);
    check("rst_mid_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
    start_frame(8'd5, 8'd5);
    finish_frame("after_rst", 8'd5, 8'd5, 4, 8'h05, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
